// File: rtl/axis_verdict_gate_if.sv
// axis_verdict_gate_if: AXI4-Stream bundle (tdata/tkeep/tid/tlast/tvalid/tready).
//   master : drives payload + tvalid, samples tready
//   slave  : samples payload + tvalid, drives tready
interface axis_verdict_gate_if #(
  parameter int DATA_W = 512,
  parameter int ID_W   = 6
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [ID_W-1:0]     tid;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tid, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tid, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_verdict_gate.sv
// axis_verdict_gate: store-and-gate stage for the verify path.
// Buffers complete AXI4-Stream packets, pairs each one in order with a 1-bit
// verdict (1 = pass, 0 = fail) and forwards, drops (FAIL_MODE=0) or scrubs
// the last beat's tdata (FAIL_MODE=1) of the packet.
//
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   s_axis (slave)      input packet stream
//   verdict_t*          verdict stream (1 bit)
//   m_axis (master)     output packet stream
//   pkts_pending        complete packets currently buffered
//   err_oversize        sticky: buffer filled by a single packet, input stalled
//   pass_cnt/fail_cnt   completion counters (0 unless stats are built)
//
// Optional: define VERDICT_GATE_STATS_EN to build the saturating pass/fail
// counters; otherwise both outputs are tied to 0.
// DEPTH and MAX_PKTS are powers of 2; MAX_PKTS >= 2.
module axis_verdict_gate #(
  parameter int DATA_W    = 512,
  parameter int ID_W      = 6,
  parameter int DEPTH     = 64,
  parameter int MAX_PKTS  = 8,
  parameter int FAIL_MODE = 0
) (
  input  logic                           aclk,
  input  logic                           areset,
  axis_verdict_gate_if.slave             s_axis,
  input  logic                           verdict_tdata,
  input  logic                           verdict_tvalid,
  output logic                           verdict_tready,
  axis_verdict_gate_if.master            m_axis,
  output logic [$clog2(MAX_PKTS+1)-1:0]  pkts_pending,
  output logic                           err_oversize,
  output logic [31:0]                    pass_cnt,
  output logic [31:0]                    fail_cnt
);
  localparam int KW  = DATA_W/8;
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = $clog2(MAX_PKTS+1);
  localparam int VAW = $clog2(MAX_PKTS);
  localparam logic [PW-1:0] PKTS_MAX = PW'(MAX_PKTS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KW-1:0]     keep;
    logic [ID_W-1:0]   id;
    logic              last;
  } beat_t;

  typedef enum logic [1:0] {IDLE, PASS, FAIL} state_t;

  // packet buffer; pointers carry one extra wrap bit
  beat_t         mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          buf_full, buf_empty;
  beat_t         wr_beat, rd_beat;

  // verdict queue
  logic [MAX_PKTS-1:0] vq_mem;
  logic [VAW-1:0]      vq_wr, vq_rd;
  logic [PW-1:0]       vq_cnt;
  logic                vq_push, vq_pop, vq_empty;

  state_t state, state_nxt;
  logic   fetch_done;   // tlast beat of current packet already in the output reg
  logic   m_vld;
  beat_t  m_beat;
  logic   s_fire, stream, discard, load, drop, retire;

  assign buf_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign buf_empty = (wptr == rptr);
  assign rd_beat   = mem[rptr[AW-1:0]];
  assign wr_beat   = '{data: s_axis.tdata, keep: s_axis.tkeep,
                       id: s_axis.tid, last: s_axis.tlast};

  assign s_axis.tready  = !areset && !buf_full && (pkts_pending != PKTS_MAX) && !err_oversize;
  assign s_fire         = s_axis.tvalid && s_axis.tready;

  assign verdict_tready = !areset && (vq_cnt != PKTS_MAX);
  assign vq_push        = verdict_tvalid && verdict_tready;
  assign vq_empty       = (vq_cnt == '0);

  // FAIL with FAIL_MODE=1 streams exactly like PASS; only the load data differs
  assign stream  = (state == PASS) || (state == FAIL && FAIL_MODE == 1);
  assign discard = (state == FAIL) && (FAIL_MODE == 0);
  // output register refills whenever it is empty or being drained: 1 beat/cycle
  assign load    = stream && !fetch_done && !buf_empty && (!m_vld || m_axis.tready);
  assign drop    = discard && !buf_empty;
  assign retire  = (m_vld && m_axis.tready && m_beat.last) || (drop && rd_beat.last);

  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata  = m_beat.data;
  assign m_axis.tkeep  = m_beat.keep;
  assign m_axis.tid    = m_beat.id;
  assign m_axis.tlast  = m_beat.last;

  always_comb begin
    state_nxt = state;
    vq_pop    = 1'b0;
    case (state)
      IDLE: if (pkts_pending != '0 && !vq_empty) begin
        vq_pop    = 1'b1;
        state_nxt = vq_mem[vq_rd] ? PASS : FAIL;
      end
      PASS, FAIL: if (retire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // storage without reset: validity is tracked by the pointers/counts
  always_ff @(posedge aclk) begin
    if (s_fire)  mem[wptr[AW-1:0]] <= wr_beat;
    if (vq_push) vq_mem[vq_wr]     <= verdict_tdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      wptr         <= '0;
      rptr         <= '0;
      vq_wr        <= '0;
      vq_rd        <= '0;
      vq_cnt       <= '0;
      pkts_pending <= '0;
      err_oversize <= 1'b0;
      fetch_done   <= 1'b0;
      m_vld        <= 1'b0;
      m_beat       <= '0;
    end else begin
      state <= state_nxt;
      wptr  <= wptr + (AW+1)'(s_fire);
      rptr  <= rptr + (AW+1)'(load || drop);
      vq_wr <= vq_wr + VAW'(vq_push);
      vq_rd <= vq_rd + VAW'(vq_pop);

      case ({vq_push, vq_pop})
        2'b10:   vq_cnt <= vq_cnt + 1'b1;
        2'b01:   vq_cnt <= vq_cnt - 1'b1;
        default: vq_cnt <= vq_cnt;
      endcase

      case ({s_fire && s_axis.tlast, retire})
        2'b10:   pkts_pending <= pkts_pending + 1'b1;
        2'b01:   pkts_pending <= pkts_pending - 1'b1;
        default: pkts_pending <= pkts_pending;
      endcase

      // a full buffer holding no complete packet can never drain
      if (buf_full && pkts_pending == '0) err_oversize <= 1'b1;

      if (retire)                     fetch_done <= 1'b0;
      else if (load && rd_beat.last)  fetch_done <= 1'b1;

      if (load) begin
        m_vld  <= 1'b1;
        m_beat <= rd_beat;
        if (state == FAIL && rd_beat.last) m_beat.data <= '0;
      end else if (m_axis.tready) begin
        m_vld  <= 1'b0;
      end
    end
  end

`ifdef VERDICT_GATE_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (retire) begin
      if (state == PASS && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      if (state == FAIL && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
    end
  end
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_verdict_gate.sv
// Bench for axis_verdict_gate: two instances (FAIL_MODE 0 and 1, DEPTH=4,
// MAX_PKTS=2). A queue-level packet/verdict model predicts the output beat
// stream; a negedge monitor checks every handshake and stall stability,
// directed sequences add literal expectations.
module tb_axis_verdict_gate;
  localparam int DW = 32, IW = 6, KW = 4, DEP = 4, MP = 2, PW = $clog2(MP+1);
`ifdef VERDICT_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic aclk;
  logic          rst [2];
  logic [DW-1:0] s_data [2];
  logic [KW-1:0] s_keep [2];
  logic [IW-1:0] s_id [2];
  logic          s_last [2], s_valid [2], s_ready [2];
  logic          v_data [2], v_valid [2], v_ready [2];
  logic [DW-1:0] m_data [2];
  logic [KW-1:0] m_keep [2];
  logic [IW-1:0] m_id [2];
  logic          m_last [2], m_valid [2], m_ready [2];
  logic [PW-1:0] pend_cnt [2];
  logic          err [2];
  logic [31:0]   pcnt [2], fcnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_verdict_gate_if #(.DATA_W(DW), .ID_W(IW)) s_if ();
    axis_verdict_gate_if #(.DATA_W(DW), .ID_W(IW)) m_if ();
    assign s_if.tdata  = s_data[g];
    assign s_if.tkeep  = s_keep[g];
    assign s_if.tid    = s_id[g];
    assign s_if.tlast  = s_last[g];
    assign s_if.tvalid = s_valid[g];
    assign s_ready[g]  = s_if.tready;
    assign m_if.tready = m_ready[g];
    assign m_data[g]   = m_if.tdata;
    assign m_keep[g]   = m_if.tkeep;
    assign m_id[g]     = m_if.tid;
    assign m_last[g]   = m_if.tlast;
    assign m_valid[g]  = m_if.tvalid;
    axis_verdict_gate #(.DATA_W(DW), .ID_W(IW), .DEPTH(DEP), .MAX_PKTS(MP),
                        .FAIL_MODE(g)) u_dut (
      .aclk(aclk), .areset(rst[g]), .s_axis(s_if),
      .verdict_tdata(v_data[g]), .verdict_tvalid(v_valid[g]), .verdict_tready(v_ready[g]),
      .m_axis(m_if), .pkts_pending(pend_cnt[g]), .err_oversize(err[g]),
      .pass_cnt(pcnt[g]), .fail_cnt(fcnt[g]));
  end

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- model ----------------
  beat_t cur [2][$];
  beat_t pend [2][$];
  int    pend_len [2][$];
  bit    vq [2][$];
  beat_t expq [2][$];
  beat_t hs [2][$];
  int    hs_cyc [2][$];
  int    mp [2], mf [2];
  bit    stall_prev [2];
  beat_t prev_beat [2];
  int    stall_seen = 0;

  always @(negedge aclk) begin
    for (int k = 0; k < 2; k++) begin
      beat_t b;
      b = '{data: m_data[k], keep: m_keep[k], id: m_id[k], last: m_last[k]};
      if (rst[k]) begin
        cur[k].delete(); pend[k].delete(); pend_len[k].delete(); vq[k].delete();
        expq[k].delete(); mp[k] = 0; mf[k] = 0; stall_prev[k] = 0;
        continue;
      end
      if (s_valid[k] && s_ready[k]) begin
        cur[k].push_back('{data: s_data[k], keep: s_keep[k], id: s_id[k], last: s_last[k]});
        if (s_last[k]) begin
          pend_len[k].push_back(cur[k].size());
          while (cur[k].size() > 0) pend[k].push_back(cur[k].pop_front());
        end
      end
      if (v_valid[k] && v_ready[k]) vq[k].push_back(v_data[k]);
      while (pend_len[k].size() > 0 && vq[k].size() > 0) begin
        int n; bit v;
        n = pend_len[k].pop_front();
        v = vq[k].pop_front();
        for (int i = 0; i < n; i++) begin
          beat_t e;
          e = pend[k].pop_front();
          if (v) expq[k].push_back(e);
          else if (k == 1) begin
            if (i == n-1) e.data = '0;
            expq[k].push_back(e);
          end
        end
        if (v) mp[k]++; else mf[k]++;
      end
      if (stall_prev[k]) begin
        chk($sformatf("stall_valid%0d", k), 64'(m_valid[k]), 64'd1);
        chk($sformatf("stall_hold%0d", k), 64'(b), 64'(prev_beat[k]));
      end
      if (m_valid[k] && m_ready[k]) begin
        if (expq[k].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat%0d: got %0h expected none", k, b);
        end else begin
          chk($sformatf("beat%0d", k), 64'(b), 64'(expq[k].pop_front()));
        end
        hs[k].push_back(b);
        hs_cyc[k].push_back(cyc);
      end
      if (m_valid[k] && !m_ready[k]) stall_seen++;
      stall_prev[k] = m_valid[k] && !m_ready[k];
      prev_beat[k]  = b;
    end
  end

  // ---------------- stimulus helpers ----------------
  int vcyc;

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic send_beat(input int k, input logic [DW-1:0] d, input logic [KW-1:0] kp,
                           input logic [IW-1:0] id, input logic l);
    bit ok = 0;
    s_data[k] = d; s_keep[k] = kp; s_id[k] = id; s_last[k] = l; s_valid[k] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_ready[k]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL s_timeout%0d: got no tready expected tready", k);
    end
    tick();
    s_valid[k] = 1'b0;
  endtask

  task automatic send_verdict(input int k, input logic v);
    bit ok = 0;
    v_data[k] = v; v_valid[k] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (v_ready[k]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL v_timeout%0d: got no tready expected tready", k);
    end
    tick();
    vcyc = cyc;
    v_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (expq[k].size() == 0 && pend_len[k].size() == 0 && !m_valid[k] && pend_cnt[k] == '0) begin
        ok = 1; break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL drain%0d: got %0d beats outstanding expected 0", k, expq[k].size());
    end
    tick();
  endtask

  // ---------------- directed sequence ----------------
  logic [0:3] pat = 4'b1001;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; s_data[k] = '0; s_keep[k] = '0; s_id[k] = '0; s_last[k] = 1'b0;
      s_valid[k] = 1'b0; v_data[k] = 1'b0; v_valid[k] = 1'b0; m_ready[k] = 1'b1;
    end
    repeat (3) tick();
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_m_valid%0d", k), 64'(m_valid[k]), 64'd0);
      chk($sformatf("rst_m_data%0d", k), 64'(m_data[k]), 64'd0);
      chk($sformatf("rst_pkts%0d", k), 64'(pend_cnt[k]), 64'd0);
      chk($sformatf("rst_err%0d", k), 64'(err[k]), 64'd0);
      chk($sformatf("rst_s_ready%0d", k), 64'(s_ready[k]), 64'd0);
      chk($sformatf("rst_v_ready%0d", k), 64'(v_ready[k]), 64'd0);
      chk($sformatf("rst_pass%0d", k), 64'(pcnt[k]), 64'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();
    @(negedge aclk);
    chk("post_rst_s_ready", 64'(s_ready[0]), 64'd1);
    chk("post_rst_v_ready", 64'(v_ready[0]), 64'd1);
    tick();

    // 3-beat pass packet, tid=5
    hs_cyc[0].delete();
    send_beat(0, 32'h1111_0001, 4'hF, 6'd5, 1'b0);
    send_beat(0, 32'h1111_0002, 4'hF, 6'd5, 1'b0);
    send_beat(0, 32'h1111_0003, 4'h3, 6'd5, 1'b1);
    @(negedge aclk);
    chk("t1_pkts_before", 64'(pend_cnt[0]), 64'd1);
    tick();
    send_verdict(0, 1'b1);
    drain(0);
    chk("t1_beats", 64'(hs_cyc[0].size()), 64'd3);
    if (hs_cyc[0].size() == 3) begin
      chk("t1_consecutive", 64'(hs_cyc[0][2] - hs_cyc[0][0]), 64'd2);
      chk("t1_latency_le2", 64'((hs_cyc[0][0] - vcyc) <= 2), 64'd1);
    end
    chk("t1_pkts_after", 64'(pend_cnt[0]), 64'd0);
    chk("t1_pass_cnt", 64'(pcnt[0]), STATS ? 64'd1 : 64'd0);

    // verdict 0 before a 4-beat packet, dropped
    hs_cyc[0].delete();
    send_verdict(0, 1'b0);
    send_beat(0, 32'h2222_0001, 4'hF, 6'd7, 1'b0);
    send_beat(0, 32'h2222_0002, 4'hF, 6'd7, 1'b0);
    send_beat(0, 32'h2222_0003, 4'hF, 6'd7, 1'b0);
    send_beat(0, 32'h2222_0004, 4'hF, 6'd7, 1'b1);
    @(negedge aclk);
    chk("t2_pkts_full", 64'(pend_cnt[0]), 64'd1);
    repeat (6) tick();
    @(negedge aclk);
    chk("t2_pkts_after", 64'(pend_cnt[0]), 64'd0);
    chk("t2_no_output", 64'(hs_cyc[0].size()), 64'd0);
    chk("t2_fail_cnt", 64'(fcnt[0]), STATS ? 64'd1 : 64'd0);
    tick();

    // FAIL_MODE=1: scrub last beat
    hs[1].delete();
    send_beat(1, 32'hAAAA_AAAA, 4'hF, 6'd9, 1'b0);
    send_beat(1, 32'hAAAA_AAAA, 4'h7, 6'd9, 1'b1);
    send_verdict(1, 1'b0);
    drain(1);
    chk("t3_beats", 64'(hs[1].size()), 64'd2);
    if (hs[1].size() == 2) begin
      chk("t3_b1_data", 64'(hs[1][0].data), 64'hAAAA_AAAA);
      chk("t3_b2_data", 64'(hs[1][1].data), 64'd0);
      chk("t3_b2_keep", 64'(hs[1][1].keep), 64'h7);
      chk("t3_b2_last", 64'(hs[1][1].last), 64'd1);
    end
    chk("t3_fail_cnt", 64'(fcnt[1]), STATS ? 64'd1 : 64'd0);

    // MAX_PKTS limit with single-beat packets
    hs[0].delete();
    send_beat(0, 32'h3333_0001, 4'hF, 6'd1, 1'b1);
    send_beat(0, 32'h3333_0002, 4'hF, 6'd2, 1'b1);
    @(negedge aclk);
    chk("t4_s_ready_low", 64'(s_ready[0]), 64'd0);
    chk("t4_pkts2", 64'(pend_cnt[0]), 64'd2);
    tick();
    send_verdict(0, 1'b1);
    send_verdict(0, 1'b0);
    drain(0);
    chk("t4_one_out", 64'(hs[0].size()), 64'd1);
    chk("t4_s_ready_back", 64'(s_ready[0]), 64'd1);

    // backpressure toggling during PASS
    m_ready[0] = 1'b0;
    hs[0].delete();
    send_beat(0, 32'h4444_0001, 4'hF, 6'd3, 1'b0);
    send_beat(0, 32'h4444_0002, 4'hE, 6'd3, 1'b0);
    send_beat(0, 32'h4444_0003, 4'hC, 6'd3, 1'b1);
    send_verdict(0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      m_ready[0] = pat[i % 4];
      tick();
    end
    m_ready[0] = 1'b1;
    drain(0);
    chk("t5_beats", 64'(hs[0].size()), 64'd3);
    chk("t5_stall_seen", 64'(stall_seen > 0), 64'd1);

    // oversize on a 5-beat packet with DEPTH=4
    for (int i = 0; i < 4; i++) send_beat(0, 32'h5555_0000 + 32'(i), 4'hF, 6'd4, 1'b0);
    tick();
    @(negedge aclk);
    chk("t6_err_set", 64'(err[0]), 64'd1);
    chk("t6_s_ready_low", 64'(s_ready[0]), 64'd0);
    tick();
    rst[0] = 1'b1;
    tick(); tick();
    rst[0] = 1'b0;
    tick();
    @(negedge aclk);
    chk("t6_err_clr", 64'(err[0]), 64'd0);
    chk("t6_pkts_clr", 64'(pend_cnt[0]), 64'd0);
    chk("t6_s_ready_back", 64'(s_ready[0]), 64'd1);
    tick();
    hs[0].delete();
    send_beat(0, 32'h6666_0001, 4'hF, 6'd6, 1'b0);
    send_beat(0, 32'h6666_0002, 4'h1, 6'd6, 1'b1);
    send_verdict(0, 1'b1);
    drain(0);
    chk("t6_beats", 64'(hs[0].size()), 64'd2);
    chk("t6_pass_cnt", 64'(pcnt[0]), STATS ? 64'd1 : 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
